adc_s2p_mc: RTL and testbench
=============================

Name: adc_s2p_mc

Overview:
Parametrised multi-lane successor to the two-stream ADC serial-to-parallel converter. Deserialises NLANE synchronous ADC serial lanes into DWIDTH-bit words and packs one word per lane into a single frame entry. Buffers frames in a small show-ahead FIFO with a valid/ready output handshake. Sits between the ADC serial interface and the UART/packetiser path, with overflow and framing-error reporting.

Parameters:
- DWIDTH, 12, bits per ADC sample; must be >= 2.
- NLANE, 2, number of serial data lanes, 1..8.
- FIFO_DEPTH, 4, frame entries buffered; power of two, >= 2.
- MSB_FIRST, 1, 1: first serial bit is the word MSB; 0: first bit is the LSB.

Ports:
- clk10m  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- adc_sdata  in  NLANE  serial data, one bit per lane; sampled only when adc_bit_en=1.
- adc_bit_en  in  1  bit strobe; qualifies adc_sdata and adc_sync.
- adc_sync  in  1  word sync; 1 on a bit_en cycle marks bit 0 of a new word.
- pdo  out  NLANE*DWIDTH  FIFO head; lane i at pdo[i*DWIDTH +: DWIDTH].
- pdo_valid  out  1  head entry valid.
- pdo_ready  in  1  consumer accepts the head when pdo_valid & pdo_ready.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- ferr_cnt  out  8  framing-error count; saturates at 255.

Behaviour:
- Reset values: pdo=0, pdo_valid=0, fifo_level=0, ovf=0, ferr_cnt=0, FSM=IDLE, bit counter=0. FIFO pointers cleared. Any partial word is discarded.
- Cycles with adc_bit_en=0 are ignored by the FSM. Gaps of any length between bits are legal.
- IDLE: bit_en & sync captures bit 0 of every lane, sets cnt=1, and moves to SHIFT. bit_en & !sync stays in IDLE and discards the bit.
- SHIFT, bit_en & !sync: shift in one bit per lane and increment cnt.
  - When the captured bit is bit DWIDTH-1, the frame is complete. Push it to the FIFO at that same edge and return to IDLE.
- SHIFT, bit_en & sync: framing error. Discard the partial word and increment ferr_cnt (saturating). Treat the current bit as bit 0 of a new word (cnt=1, stay in SHIFT).
- Bit placement: with MSB_FIRST=1, bit k goes to position DWIDTH-1-k. With MSB_FIRST=0, bit k goes to position k.
- Latency: pdo_valid rises in the clock cycle after the edge that samples the last bit, provided the FIFO was empty. pdo then shows the new frame.
- FIFO is show-ahead: pdo always reflects the head entry. A pop happens on any edge where pdo_valid & pdo_ready.
- Push when full:
  - If a pop occurs on the same edge, the push is accepted and fifo_level stays at FIFO_DEPTH.
  - Otherwise the new frame is dropped, ovf is set, and FIFO contents are unchanged.
- Push and pop on the same edge when not full: fifo_level is unchanged.
- Pop when empty is impossible, since pdo_valid=0.
- ovf_clr=1 clears ovf on the next edge. If a new overflow occurs on the same edge, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- pdo content is don't-care-stable when pdo_valid=0: it holds the last head value.

Optional Feature:
ADC_S2P_SEQ_EN
- Defined: adds output pdo_seq [7:0]. An 8-bit frame counter, reset to 0, is stored alongside each pushed frame and increments on every completed frame, including dropped ones (wraps 255->0). The consumer can therefore detect drops from sequence gaps. pdo_seq is the head entry's tag and is 0 out of reset.
- Not defined: no pdo_seq port, no counter, and no extra FIFO width.

Test Plan:
- Basic MSB-first frame: DWIDTH=12, NLANE=2, bit_en held at 1, pdo_ready=1, lane0=0xA5C, lane1=0x3F1 -> pdo=0x3F1A5C, pdo_valid high exactly 1 cycle, starting 1 cycle after the last-bit edge.
- Gapped strobe: bit_en every 3rd cycle with random sdata between strobes, MSB_FIRST=0, lane0 sent as 0x123 -> pdo[11:0]=0x123, with no effect from non-strobe data.
- Overflow: pdo_ready=0, 5 frames 0x001..0x005 on lane0 -> fifo_level=4, ovf=1. Then pdo_ready=1 -> pops 0x001..0x004, and 0x005 is absent. ovf_clr pulse -> ovf=0.
- Full with simultaneous push and pop: FIFO holds 4 entries and a last bit lands on the same edge as a pop -> level stays 4, ovf stays 0, and the new frame appears 4th.
- Framing error: sync reasserted on bit 6 of a word, followed by a clean 12-bit word 0xFFF -> ferr_cnt=1, and the single output is 0xFFF. 300 errors -> ferr_cnt=255.
- Reset mid-word: rst_n low after bit 7 -> outputs at reset values immediately. After release, the next full frame 0x800 decodes correctly.

Source files
------------

// File: rtl/adc_s2p_mc.sv
// adc_s2p_mc: multi-lane ADC serial-to-parallel converter with frame FIFO.
//
// Deserialises NLANE synchronous serial lanes into DWIDTH-bit words. It packs
// one word per lane into a frame and buffers the frames in a show-ahead FIFO
// with a valid/ready output.
//
// Ports:
//   clk10m      in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   adc_sdata   in   [NLANE]  serial data, one bit per lane
//   adc_bit_en  in   bit strobe qualifying adc_sdata / adc_sync
//   adc_sync    in   marks bit 0 of a new word (on a bit_en cycle)
//   pdo         out  [NLANE*DWIDTH] FIFO head, lane i at pdo[i*DWIDTH +: DWIDTH]
//   pdo_valid   out  head entry valid
//   pdo_ready   in   consumer pops head when pdo_valid & pdo_ready
//   fifo_level  out  entries held, 0..FIFO_DEPTH
//   ovf         out  sticky overflow flag
//   ovf_clr     in   clears ovf (a coincident overflow wins)
//   pdo_seq     out  [8] head frame sequence tag (ADC_S2P_SEQ_EN only)
//   ferr_cnt    out  [8] saturating framing-error count
//
// Build option: define ADC_S2P_SEQ_EN to tag each frame with an 8-bit
// sequence number. The number advances on every completed frame, including
// frames that are dropped on overflow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a sync-qualified bit 0
// S_SHIFT | word in progress; cnt_q = number of bits captured so far
module adc_s2p_mc #(
  parameter int DWIDTH     = 12,
  parameter int NLANE      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                               clk10m,
  input  logic                               rst_n,
  input  logic [NLANE-1:0]                   adc_sdata,
  input  logic                               adc_bit_en,
  input  logic                               adc_sync,
  output logic [NLANE*DWIDTH-1:0]            pdo,
  output logic                               pdo_valid,
  input  logic                               pdo_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               ovf,
  input  logic                               ovf_clr,
`ifdef ADC_S2P_SEQ_EN
  output logic [7:0]                         pdo_seq,
`endif
  output logic [7:0]                         ferr_cnt
);

  localparam int CW = $clog2(DWIDTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = NLANE * DWIDTH;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start, shift, push, ferr;
  logic [FW-1:0]   sh_q, frame;
  logic [DWIDTH-1:0] lane_base, lane_new;

  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic            pop, full, push_ok, empty_after_pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    shift   = 1'b0;
    push    = 1'b0;
    ferr    = 1'b0;
    if (adc_bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (adc_sync) begin
            start   = 1'b1;
            cnt_d   = CW'(1);
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (adc_sync) begin
            // early sync: drop the partial word, this bit opens a new one
            start = 1'b1;
            ferr  = 1'b1;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(DWIDTH - 1)) begin
            shift   = 1'b1;
            push    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next shift-register contents. When a word starts, the old contents are
  // ignored. The completed frame therefore comes straight from this logic,
  // which lets it be pushed on the same edge that samples the last bit.
  always_comb begin
    frame     = '0;
    lane_base = '0;
    lane_new  = '0;
    for (int i = 0; i < NLANE; i++) begin
      lane_base = start ? '0 : sh_q[i*DWIDTH +: DWIDTH];
      if (MSB_FIRST != 0)
        lane_new = (lane_base << 1) | DWIDTH'(adc_sdata[i]);
      else
        lane_new = (lane_base >> 1) | {adc_sdata[i], {(DWIDTH-1){1'b0}}};
      frame[i*DWIDTH +: DWIDTH] = lane_new;
    end
  end

  assign pdo_valid       = (fifo_level != '0);
  assign full            = (fifo_level == LW'(FIFO_DEPTH));
  assign pop             = pdo_valid & pdo_ready;
  assign push_ok         = push & (~full | pop);
  assign rd_next         = rd_ptr + PW'(pop);
  // The new frame becomes the head only if nothing older remains after the pop.
  assign empty_after_pop = (fifo_level == LW'(pop));

  always_ff @(posedge clk10m) begin
    if (push_ok) mem[wr_ptr] <= frame;
  end

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pdo        <= '0;
      ovf        <= 1'b0;
      ferr_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start | shift) sh_q <= frame;
      if (ferr && ferr_cnt != 8'hFF) ferr_cnt <= ferr_cnt + 8'd1;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_next;
      fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);
      // pdo is a registered copy of the head; it holds when the FIFO drains
      if (push_ok && empty_after_pop) pdo <= frame;
      else if (pop && !empty_after_pop) pdo <= mem[rd_next];
      if (push && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

`ifdef ADC_S2P_SEQ_EN
  logic [7:0] seq_cnt;
  logic [7:0] seq_mem [FIFO_DEPTH];

  always_ff @(posedge clk10m) begin
    if (push_ok) seq_mem[wr_ptr] <= seq_cnt;
  end

  always_ff @(posedge clk10m or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
      pdo_seq <= '0;
    end else begin
      if (push) seq_cnt <= seq_cnt + 8'd1;
      if (push_ok && empty_after_pop) pdo_seq <= seq_cnt;
      else if (pop && !empty_after_pop) pdo_seq <= seq_mem[rd_next];
    end
  end
`endif

endmodule

// File: tb/tb_adc_s2p_mc.sv
module tb_adc_s2p_mc;

  logic        clk10m = 1'b0;
  logic        rst_n;
  logic [1:0]  adc_sdata;
  logic        adc_bit_en, adc_sync, pdo_ready, ovf_clr;

  logic [23:0] pdo_m, pdo_l;
  logic        valid_m, valid_l, ovf_m, ovf_l;
  logic [2:0]  lvl_m, lvl_l;
  logic [7:0]  ferr_m, ferr_l;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_m[$];
  logic [23:0] exp_l[$];

  always #5 clk10m = ~clk10m;

  adc_s2p_mc #(.DWIDTH(12), .NLANE(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk10m(clk10m), .rst_n(rst_n), .adc_sdata(adc_sdata), .adc_bit_en(adc_bit_en),
    .adc_sync(adc_sync), .pdo(pdo_m), .pdo_valid(valid_m), .pdo_ready(pdo_ready),
    .fifo_level(lvl_m), .ovf(ovf_m), .ovf_clr(ovf_clr), .ferr_cnt(ferr_m));

  adc_s2p_mc #(.DWIDTH(12), .NLANE(2), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk10m(clk10m), .rst_n(rst_n), .adc_sdata(adc_sdata), .adc_bit_en(adc_bit_en),
    .adc_sync(adc_sync), .pdo(pdo_l), .pdo_valid(valid_l), .pdo_ready(pdo_ready),
    .fifo_level(lvl_l), .ovf(ovf_l), .ovf_clr(ovf_clr), .ferr_cnt(ferr_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] rev12(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = v[11-i];
    return r;
  endfunction

  // Monitors: each accepted head is compared with the oldest expected frame.
  always @(negedge clk10m) begin
    if (rst_n && valid_m && pdo_ready) begin
      if (exp_m.size() == 0) check("msb_unexpected_frame", {8'h0, pdo_m}, 32'hFFFF_FFFF);
      else check("msb_frame", {8'h0, pdo_m}, {8'h0, exp_m.pop_front()});
    end
  end

  always @(negedge clk10m) begin
    if (rst_n && valid_l && pdo_ready) begin
      if (exp_l.size() == 0) check("lsb_unexpected_frame", {8'h0, pdo_l}, 32'hFFFF_FFFF);
      else check("lsb_frame", {8'h0, pdo_l}, {8'h0, exp_l.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk10m);
    #1;
  endtask

  // Sends one word per lane, first bit = word bit 11, sync on the first bit.
  // gap idle cycles (random data/sync) follow every bit except the last.
  task automatic send_frame(input logic [11:0] l0, input logic [11:0] l1, input int gap,
                            input bit expect_out, input bit pop_on_last);
    for (int k = 0; k < 12; k++) begin
      adc_bit_en = 1'b1;
      adc_sdata  = {l1[11-k], l0[11-k]};
      adc_sync   = (k == 0);
      if (pop_on_last && k == 11) pdo_ready = 1'b1;
      tick();
      if (pop_on_last && k == 11) pdo_ready = 1'b0;
      if (k < 11) begin
        for (int g = 0; g < gap; g++) begin
          adc_bit_en = 1'b0;
          adc_sdata  = 2'($urandom);
          adc_sync   = 1'($urandom);
          tick();
        end
      end
    end
    adc_bit_en = 1'b0;
    adc_sync   = 1'b0;
    if (expect_out) begin
      exp_m.push_back({l1, l0});
      exp_l.push_back({rev12(l1), rev12(l0)});
    end
  endtask

  task automatic send_bits(input int n);
    for (int k = 0; k < n; k++) begin
      adc_bit_en = 1'b1;
      adc_sdata  = 2'b10;
      adc_sync   = (k == 0);
      tick();
    end
    adc_bit_en = 1'b0;
    adc_sync   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; adc_sdata = '0; adc_bit_en = 1'b0; adc_sync = 1'b0;
    pdo_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    check("rst_pdo", {8'h0, pdo_m}, 32'h0);
    check("rst_valid", {31'h0, valid_m}, 32'h0);
    check("rst_level", {29'h0, lvl_m}, 32'h0);
    check("rst_ovf", {31'h0, ovf_m}, 32'h0);
    check("rst_ferr", {24'h0, ferr_m}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic MSB-first frame, continuous strobe
    pdo_ready = 1'b1;
    send_frame(12'hA5C, 12'h3F1, 0, 1'b1, 1'b0);
    @(negedge clk10m);
    check("basic_valid_rise", {31'h0, valid_m}, 32'h1);
    check("basic_pdo", {8'h0, pdo_m}, 32'h003F_1A5C);
    @(negedge clk10m);
    check("basic_valid_one_cycle", {31'h0, valid_m}, 32'h0);
    repeat (2) tick();

    // Gapped strobe; LSB-first instance should decode lane0 as 0x123
    send_frame(12'hC48, 12'h0F0, 2, 1'b1, 1'b0);
    @(negedge clk10m);
    check("gap_lsb_valid", {31'h0, valid_l}, 32'h1);
    check("gap_lsb_lane0", {20'h0, pdo_l[11:0]}, 32'h123);
    repeat (3) tick();

    // Overflow: five frames with no consumer
    pdo_ready = 1'b0;
    for (int f = 1; f <= 5; f++) send_frame(12'(f), 12'h000, 0, (f <= 4), 1'b0);
    @(negedge clk10m);
    check("ovf_level", {29'h0, lvl_m}, 32'h4);
    check("ovf_set", {31'h0, ovf_m}, 32'h1);
    check("ovf_set_lsb", {31'h0, ovf_l}, 32'h1);
    tick();
    pdo_ready = 1'b1;
    repeat (6) tick();
    check("ovf_drain_level", {29'h0, lvl_m}, 32'h0);
    check("ovf_drain_queue", exp_m.size(), 32'h0);
    check("ovf_sticky", {31'h0, ovf_m}, 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", {31'h0, ovf_m}, 32'h0);

    // Full FIFO with push and pop on the same edge
    pdo_ready = 1'b0;
    for (int f = 1; f <= 4; f++) send_frame(12'(16 + f), 12'h0AA, 0, 1'b1, 1'b0);
    @(negedge clk10m);
    check("full_level", {29'h0, lvl_m}, 32'h4);
    tick();
    send_frame(12'h015, 12'h0AA, 0, 1'b1, 1'b1);
    @(negedge clk10m);
    check("full_pushpop_level", {29'h0, lvl_m}, 32'h4);
    check("full_pushpop_ovf", {31'h0, ovf_m}, 32'h0);
    tick();
    pdo_ready = 1'b1;
    repeat (6) tick();
    check("full_drain_queue", exp_m.size(), 32'h0);

    // Framing error, then a clean word
    send_bits(6);
    send_frame(12'hFFF, 12'hFFF, 0, 1'b1, 1'b0);
    @(negedge clk10m);
    check("ferr_one", {24'h0, ferr_m}, 32'h1);
    check("ferr_word", {8'h0, pdo_m}, 32'h00FF_FFFF);
    repeat (3) tick();
    check("ferr_single_output", exp_m.size(), 32'h0);
    send_bits(1);
    for (int e = 0; e < 300; e++) begin
      adc_bit_en = 1'b1;
      adc_sync   = 1'b1;
      tick();
    end
    adc_bit_en = 1'b0;
    adc_sync   = 1'b0;
    check("ferr_saturate", {24'h0, ferr_m}, 32'hFF);
    check("ferr_saturate_lsb", {24'h0, ferr_l}, 32'hFF);

    // Reset in the middle of a word with a frame buffered
    pdo_ready = 1'b0;
    send_frame(12'h0AA, 12'h055, 0, 1'b0, 1'b0);
    send_bits(8);
    rst_n = 1'b0;
    #1;
    check("midrst_pdo", {8'h0, pdo_m}, 32'h0);
    check("midrst_valid", {31'h0, valid_m}, 32'h0);
    check("midrst_level", {29'h0, lvl_m}, 32'h0);
    check("midrst_ferr", {24'h0, ferr_m}, 32'h0);
    exp_m.delete();
    exp_l.delete();
    tick();
    rst_n = 1'b1;
    pdo_ready = 1'b1;
    tick();
    send_frame(12'h800, 12'h001, 0, 1'b1, 1'b0);
    @(negedge clk10m);
    check("postrst_valid", {31'h0, valid_m}, 32'h1);
    check("postrst_lane0", {20'h0, pdo_m[11:0]}, 32'h800);
    repeat (4) tick();
    check("final_queue_msb", exp_m.size(), 32'h0);
    check("final_queue_lsb", exp_l.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
